// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MIPS data-memory responder.
// MMIO register offsets, the out-of-range read pattern and the region decode.
package mips_mem_pkg;

    localparam logic [3:0]  OFF_CYCLES    = 4'h0;
    localparam logic [3:0]  OFF_GPIO      = 4'h4;
    localparam logic [3:0]  OFF_FAULT     = 4'h8;
    localparam logic [31:0] FAULT_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_BAD
    } region_t;

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Four 8-bit synchronous RAM lanes, per-lane write enable, shared read port.
// Read-first: a same-edge read returns the pre-write contents.
module dmem_bytelane_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [0:(2**ADDR_WIDTH)-1];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (we[i])
                mem[addr] <= wdata[8*i +: 8];
            if (re)
                q <= mem[addr];
        end

        assign rdata[8*i +: 8] = q;
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: byte-lane RAM plus a 16-byte MMIO window
// (cycle counter, GPIO, sticky access fault). Read data is registered.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_read_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic [7:0]  gpio_out,
    output logic        access_fault
);

    region_t     region;
    region_t     rd_src_q;
    logic [3:0]  off;
    logic [31:0] cycles_q;
    logic [31:0] gpio_q;
    logic        fault_q;
    logic [31:0] mmio_rdata;
    logic [31:0] rd_q;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic        access;
    logic        fault_set;
    logic        fault_clr;
    logic        gpio_we;
    logic        unused_bits;

    assign unused_bits = ^mem_addr[1:0];
    assign off         = {mem_addr[3:2], 2'b00};

    always_comb begin
        region = REG_BAD;
        if (mem_addr[31:ADDR_WIDTH+2] == '0)
            region = REG_RAM;
        else if (mem_addr[31:4] == MMIO_BASE[31:4])
            region = REG_MMIO;
    end

    always_comb begin
        mmio_rdata = '0;
        case (off)
            OFF_CYCLES: mmio_rdata = cycles_q;
            OFF_GPIO:   mmio_rdata = gpio_q;
            OFF_FAULT:  mmio_rdata = {31'b0, fault_q};
            default:    mmio_rdata = '0;
        endcase
    end

    assign access    = mem_read_en || (mem_write_en != 4'b0);
    assign fault_set = access && (region == REG_BAD);
    assign fault_clr = (region == REG_MMIO) && (off == OFF_FAULT) &&
                       mem_write_en[0] && mem_write_data[0];
    assign gpio_we   = (region == REG_MMIO) && (off == OFF_GPIO);

    assign ram_we = (en && region == REG_RAM) ? mem_write_en : 4'b0;
    assign ram_re = en && mem_read_en && (region == REG_RAM);

    dmem_bytelane_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (mem_addr[ADDR_WIDTH+1:2]),
        .wdata (mem_write_data),
        .rdata (ram_rdata)
    );

    // Non-RAM sources are captured here; reset points the mux at rd_q
    // so an in-flight RAM read is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_src_q <= REG_MMIO;
            rd_q     <= '0;
            cycles_q <= '0;
            gpio_q   <= '0;
            fault_q  <= 1'b0;
        end else if (en) begin
            cycles_q <= cycles_q + 32'd1;
            if (mem_read_en) begin
                rd_src_q <= region;
                rd_q     <= (region == REG_BAD) ? FAULT_PATTERN : mmio_rdata;
            end
            for (int i = 0; i < 4; i++) begin
                if (gpio_we && mem_write_en[i])
                    gpio_q[8*i +: 8] <= mem_write_data[8*i +: 8];
            end
            if (fault_set)
                fault_q <= 1'b1;
            else if (fault_clr)
                fault_q <= 1'b0;
        end
    end

    assign mem_read_data = (rd_src_q == REG_RAM) ? ram_rdata : rd_q;
    assign gpio_out      = gpio_q[7:0];
    assign access_fault  = fault_q;

endmodule
